// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, field polynomial, FSM encoding
// and a byte extractor following the big-endian byte order of the state.
package aes_pkg;

    localparam int         AES_STATE_W = 128;
    localparam int         AES_BYTES   = 16;
    localparam logic [7:0] AES_POLY    = 8'h1b;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } mc_state_t;

    // Byte 0 is the most significant byte of the state.
    function automatic logic [7:0] get_byte(input logic [AES_STATE_W-1:0] st,
                                            input logic [3:0]             idx);
        return st[(AES_BYTES - 1 - int'(idx)) * 8 +: 8];
    endfunction

endpackage

// File: rtl/xtime.sv
// GF(2^8) multiply-by-two: shift left and fold the carry back in with the
// AES reduction polynomial. Purely combinational.
module xtime
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);

endmodule

// File: rtl/mixcol_seq.sv
// Sequential AES MixColumns: LANES output bytes per cycle, each lane owning
// a single xtime unit, with valid/ready handshakes on input and output.
module mixcol_seq
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("mixcol_seq: LANES must be 1, 2 or 4");
    end

    localparam logic [3:0] STEP     = 4'(LANES);
    localparam logic [3:0] LAST_CNT = 4'(AES_BYTES - LANES);

    mc_state_t              state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic [AES_STATE_W-1:0] src_reg, src_next;
    logic [AES_STATE_W-1:0] res_reg, res_next;

    logic [LANES-1:0][7:0]  lane_byte;
    logic [LANES-1:0][3:0]  lane_idx;

    // Lane gi produces output byte cnt+gi; the counter is always a multiple
    // of LANES so the index never crosses 15.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [3:0] k;
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] xt_in, xt_out;

        assign k  = cnt_reg + 4'(gi);
        assign a0 = get_byte(src_reg, k);
        assign a1 = get_byte(src_reg, {k[3:2], k[1:0] + 2'd1});
        assign a2 = get_byte(src_reg, {k[3:2], k[1:0] + 2'd2});
        assign a3 = get_byte(src_reg, {k[3:2], k[1:0] + 2'd3});

        assign xt_in = a0 ^ a1;

        xtime u_xtime (
            .a (xt_in),
            .y (xt_out)
        );

        assign lane_byte[gi] = xt_out ^ a1 ^ a2 ^ a3;
        assign lane_idx[gi]  = k;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        src_next   = src_reg;
        res_next   = res_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    src_next   = in_state;
                    cnt_next   = '0;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                for (int li = 0; li < LANES; li++) begin
                    res_next[(AES_BYTES - 1 - int'(lane_idx[li])) * 8 +: 8] = lane_byte[li];
                end
                cnt_next = cnt_reg + STEP;
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            src_reg   <= '0;
            res_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            src_reg   <= src_next;
            res_reg   <= res_next;
        end
    end

    assign out_state = res_reg;

endmodule

// File: tb/tb_mixcol_seq.sv
// Scoreboard bench for mixcol_seq with LANES = 1, 2 and 4 side by side.
module tb_mixcol_seq;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V2_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          in_valid;
    logic [2:0][127:0]   in_state;
    logic [2:0]          out_ready;
    logic [2:0]          in_ready;
    logic [2:0]          out_valid;
    logic [2:0]          busy;
    logic [2:0][127:0]   out_state;

    logic [127:0] exp_q [3][$];
    int           acc_cyc [3];
    int           cyc    = 0;
    int           n_cmp  = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m2(input logic [7:0] a);
        logic [7:0] s;
        s = {a[6:0], 1'b0};
        return a[7] ? (s ^ 8'h1b) : s;
    endfunction

    // Reference MixColumns written with explicit 2/3 coefficients per row.
    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [7:0]   b [16];
        logic [7:0]   o [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = s[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            o[4*c]   = m2(b[4*c]) ^ m2(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            o[4*c+1] = b[4*c] ^ m2(b[4*c+1]) ^ m2(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            o[4*c+2] = b[4*c] ^ b[4*c+1] ^ m2(b[4*c+2]) ^ m2(b[4*c+3]) ^ b[4*c+3];
            o[4*c+3] = m2(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ m2(b[4*c+3]);
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = o[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int L = 1 << gi;
        logic         ov_prev   = 1'b0;
        logic         hold_prev = 1'b0;
        logic [127:0] held      = '0;
        logic [127:0] exp_v;

        mixcol_seq #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_state  (in_state[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_state (out_state[gi]),
            .busy      (busy[gi])
        );

        always @(negedge clk) begin
            if (rst) begin
                exp_q[gi].delete();
                ov_prev   = 1'b0;
                hold_prev = 1'b0;
            end else begin
                if (in_valid[gi] && in_ready[gi]) acc_cyc[gi] = cyc;
                if (out_valid[gi] && !ov_prev)
                    chki($sformatf("latency_L%0d", L), cyc - acc_cyc[gi], 16 / L + 1);
                if (hold_prev) begin
                    chk1($sformatf("hold_valid_L%0d", L), out_valid[gi], 1'b1);
                    chk($sformatf("hold_state_L%0d", L), out_state[gi], held);
                end
                if (out_valid[gi])
                    chk1($sformatf("in_ready_in_done_L%0d", L), in_ready[gi], 1'b0);
                if (out_valid[gi] && out_ready[gi]) begin
                    if (exp_q[gi].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output_L%0d: got %h, expected no output", L, out_state[gi]);
                    end else begin
                        exp_v = exp_q[gi].pop_front();
                        chk($sformatf("out_state_L%0d", L), out_state[gi], exp_v);
                        $display("L%0d result %h", L, out_state[gi]);
                    end
                end
                hold_prev = out_valid[gi] && !out_ready[gi];
                held      = out_state[gi];
                ov_prev   = out_valid[gi];
            end
        end
    end

    // Push the expectation, present the state and hold it until accepted.
    task automatic send(input int d, input logic [127:0] s, input logic [127:0] e);
        int n = 0;
        exp_q[d].push_back(e);
        in_state[d] = s;
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            void'(exp_q[d].pop_back());
            chk1("send_timeout", 1'b0, 1'b1);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (exp_q[d].size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q[d].size());
            exp_q[d].delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_state  = '0;
        out_ready = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk1("rst_in_ready", in_ready[d], 1'b1);
            chk1("rst_out_valid", out_valid[d], 1'b0);
            chk1("rst_busy", busy[d], 1'b0);
            chk("rst_out_state", out_state[d], '0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // FIPS-197 and high-bit vectors on every lane count, latency checked by the monitor.
        for (int d = 0; d < 3; d++) begin
            send(d, FIPS_IN, FIPS_OUT);
            drain(d);
            send(d, V2_IN, V2_OUT);
            drain(d);
        end

        // Backpressure: hold the result for ten cycles, then a single-cycle ready pulse.
        out_ready[0] = 1'b0;
        send(0, V2_IN, V2_OUT);
        begin
            int n = 0;
            @(negedge clk);
            while (!out_valid[0] && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk1("bp_reach_done", out_valid[0], 1'b1);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk1("bp_valid_held", out_valid[0], 1'b1);
        chk1("bp_in_ready_low", in_ready[0], 1'b0);
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        @(negedge clk);
        chk1("bp_valid_drop", out_valid[0], 1'b0);
        chk1("bp_in_ready_rise", in_ready[0], 1'b1);
        @(posedge clk);
        #1 out_ready[0] = 1'b1;

        // Reset when the counter reaches 7, then a fresh state.
        send(0, FIPS_IN, FIPS_OUT);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("midrst_out_valid", out_valid[0], 1'b0);
        chk1("midrst_busy", busy[0], 1'b0);
        chk1("midrst_in_ready", in_ready[0], 1'b1);
        repeat (20) @(posedge clk);
        #1;
        send(0, V2_IN, V2_OUT);
        drain(0);

        // Garbage on the input while computing must not disturb the result.
        send(0, FIPS_IN, FIPS_OUT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk1("compute_busy", busy[0], 1'b1);
            @(posedge clk);
            #1;
            in_valid[0] = 1'(($urandom & 32'd1));
            in_state[0] = rnd128();
        end
        in_valid[0] = 1'b0;
        drain(0);

        // 100 random states back to back with a randomly stalling consumer.
        begin
            int           sent  = 0;
            int           guard = 0;
            logic         acc;
            logic [127:0] s;
            s = rnd128();
            exp_q[0].push_back(mix_ref(s));
            in_state[0] = s;
            in_valid[0] = 1'b1;
            while (sent < 100 && guard < 20000) begin
                @(negedge clk);
                acc = in_ready[0];
                @(posedge clk);
                #1;
                guard++;
                out_ready[0] = 1'(($urandom & 32'd1));
                if (acc) begin
                    sent++;
                    if (sent < 100) begin
                        s = rnd128();
                        exp_q[0].push_back(mix_ref(s));
                        in_state[0] = s;
                    end else begin
                        in_valid[0] = 1'b0;
                    end
                end
            end
            chki("random_sent", sent, 100);
            in_valid[0]  = 1'b0;
            out_ready[0] = 1'b1;
            drain(0);
            repeat (20) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
